// File: rtl/batch_cost_accumulator.sv
// batch_cost_accumulator: captures each finished per-sample cost from the
// cost calculator and accumulates a batch of 2^BATCH_LOG2 samples. It then
// presents the rounded average, the total and the maximum over valid/ready.
// Optional feature macro: BATCH_COST_MIN_TRACK_EN (adds min_cost output).
//
// state      | meaning
// -----------+-----------------------------------------------------------
// IDLE       | ready for a new sample, accept high
// WAIT_START | cost_en seen, waiting for calculator to leave idle (cc low)
// WAIT_DONE  | calculator running, capture cost_in when cc returns high
// ACCUM      | fold captured sample into total/max/count (one cycle)
// REPORT     | batch result valid, held until avg_ready
module batch_cost_accumulator #(
  parameter int BATCH_LOG2 = 3,
  parameter int COST_W     = 8
) (
  input  logic                     clk,
  input  logic                     n_rst,
  input  logic                     clear,
  input  logic                     cost_en,
  input  logic                     calculation_complete,
  input  logic [COST_W-1:0]        cost_in,
  output logic                     accept,
  output logic                     busy,
  output logic [BATCH_LOG2:0]      sample_count,
  output logic                     avg_valid,
  input  logic                     avg_ready,
  output logic [COST_W-1:0]        avg_cost,
  output logic [COST_W+BATCH_LOG2-1:0] batch_total,
`ifdef BATCH_COST_MIN_TRACK_EN
  output logic [COST_W-1:0]        min_cost,
`endif
  output logic [COST_W-1:0]        max_cost,
  output logic                     drop_err
);

  localparam int TW = COST_W + BATCH_LOG2;
  localparam logic [BATCH_LOG2:0] LAST_IDX = ((BATCH_LOG2+1)'(1) << BATCH_LOG2) - (BATCH_LOG2+1)'(1);
  localparam logic [TW:0] HALF = (TW+1)'(1) << (BATCH_LOG2 - 1);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    WAIT_START = 3'd1,
    WAIT_DONE  = 3'd2,
    ACCUM      = 3'd3,
    REPORT     = 3'd4
  } state_t;

  state_t state, state_next;
  logic [COST_W-1:0] sample_r;
  logic [TW:0]       rounded;

  // State register.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state decode and status outputs; clear overrides every transition.
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    busy       = 1'b1;
    avg_valid  = 1'b0;
    case (state)
      IDLE: begin
        accept = 1'b1;
        busy   = 1'b0;
        if (cost_en) state_next = WAIT_START;
      end
      WAIT_START: if (!calculation_complete) state_next = WAIT_DONE;
      WAIT_DONE:  if (calculation_complete)  state_next = ACCUM;
      ACCUM:      state_next = (sample_count == LAST_IDX) ? REPORT : IDLE;
      REPORT: begin
        avg_valid = 1'b1;
        if (avg_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    if (clear) state_next = IDLE;
  end

  // Datapath: sample capture, running total/max/count and sticky drop flag.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      sample_r     <= '0;
      batch_total  <= '0;
      sample_count <= '0;
      max_cost     <= '0;
      drop_err     <= 1'b0;
`ifdef BATCH_COST_MIN_TRACK_EN
      min_cost     <= '1;
`endif
    end else if (clear) begin
      batch_total  <= '0;
      sample_count <= '0;
      max_cost     <= '0;
      drop_err     <= 1'b0;
`ifdef BATCH_COST_MIN_TRACK_EN
      min_cost     <= '1;
`endif
    end else begin
      if (cost_en && state != IDLE) drop_err <= 1'b1;
      case (state)
        WAIT_DONE: if (calculation_complete) sample_r <= cost_in;
        ACCUM: begin
          batch_total  <= batch_total + TW'(sample_r);
          sample_count <= sample_count + 1'b1;
          if (sample_r > max_cost) max_cost <= sample_r;
`ifdef BATCH_COST_MIN_TRACK_EN
          if (sample_r < min_cost) min_cost <= sample_r;
`endif
        end
        REPORT: if (avg_ready) begin
          batch_total  <= '0;
          sample_count <= '0;
          max_cost     <= '0;
`ifdef BATCH_COST_MIN_TRACK_EN
          min_cost     <= '1;
`endif
        end
        default: ;
      endcase
    end
  end

  // Round half up; the result never exceeds COST_W bits.
  assign rounded  = {1'b0, batch_total} + HALF;
  assign avg_cost = COST_W'(rounded >> BATCH_LOG2);

endmodule

// File: tb/tb_batch_cost_accumulator.sv
// Directed testbench for batch_cost_accumulator with default parameters.
module tb_batch_cost_accumulator;

  logic        clk, n_rst, clear, cost_en, calculation_complete, avg_ready;
  logic [7:0]  cost_in;
  logic        accept, busy, avg_valid, drop_err;
  logic [3:0]  sample_count;
  logic [7:0]  avg_cost, max_cost;
  logic [10:0] batch_total;
`ifdef BATCH_COST_MIN_TRACK_EN
  logic [7:0]  min_cost;
`endif
  int checks = 0;
  int failures = 0;

  batch_cost_accumulator dut (
    .clk(clk), .n_rst(n_rst), .clear(clear), .cost_en(cost_en),
    .calculation_complete(calculation_complete), .cost_in(cost_in),
    .accept(accept), .busy(busy), .sample_count(sample_count),
    .avg_valid(avg_valid), .avg_ready(avg_ready), .avg_cost(avg_cost),
    .batch_total(batch_total),
`ifdef BATCH_COST_MIN_TRACK_EN
    .min_cost(min_cost),
`endif
    .max_cost(max_cost), .drop_err(drop_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One full calculator run; starts and ends just after a falling edge.
  task automatic feed(input logic [7:0] v);
    cost_en = 1'b1; calculation_complete = 1'b1;
    @(negedge clk);
    cost_en = 1'b0; calculation_complete = 1'b0;
    @(negedge clk);
    calculation_complete = 1'b1; cost_in = v;
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic handshake();
    avg_ready = 1'b1;
    @(negedge clk);
    avg_ready = 1'b0;
  endtask

  task automatic test_reset();
    n_rst = 1'b0; clear = 1'b0; cost_en = 1'b0; calculation_complete = 1'b1;
    avg_ready = 1'b0; cost_in = 8'd0;
    @(negedge clk); @(negedge clk);
    n_rst = 1'b1;
    @(negedge clk);
    checks++; if (accept !== 1'b1) begin failures++; $display("FAIL reset_accept got=%0d exp=1", accept); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%0d exp=0", busy); end
    checks++; if (avg_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%0d exp=0", avg_valid); end
    checks++; if (sample_count !== 4'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", sample_count); end
    checks++; if (batch_total !== 11'd0) begin failures++; $display("FAIL reset_total got=%0d exp=0", batch_total); end
    checks++; if (drop_err !== 1'b0) begin failures++; $display("FAIL reset_drop got=%0d exp=0", drop_err); end
  endtask

  task automatic test_nominal();
    logic [7:0] v;
    avg_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      v = 8'(i * 10);
      feed(v);
      if (i == 3) begin
        checks++; if (sample_count !== 4'd3) begin failures++; $display("FAIL nom_count3 got=%0d exp=3", sample_count); end
        checks++; if (batch_total !== 11'd60) begin failures++; $display("FAIL nom_total3 got=%0d exp=60", batch_total); end
      end
    end
    checks++; if (avg_valid !== 1'b1) begin failures++; $display("FAIL nom_valid got=%0d exp=1", avg_valid); end
    checks++; if (batch_total !== 11'd360) begin failures++; $display("FAIL nom_total got=%0d exp=360", batch_total); end
    checks++; if (avg_cost !== 8'd45) begin failures++; $display("FAIL nom_avg got=%0d exp=45", avg_cost); end
    checks++; if (max_cost !== 8'd80) begin failures++; $display("FAIL nom_max got=%0d exp=80", max_cost); end
`ifdef BATCH_COST_MIN_TRACK_EN
    checks++; if (min_cost !== 8'd10) begin failures++; $display("FAIL nom_min got=%0d exp=10", min_cost); end
`endif
    @(negedge clk);
    avg_ready = 1'b0;
    checks++; if (avg_valid !== 1'b0) begin failures++; $display("FAIL nom_pulse got=%0d exp=0", avg_valid); end
    checks++; if (sample_count !== 4'd0) begin failures++; $display("FAIL nom_count0 got=%0d exp=0", sample_count); end
    checks++; if (max_cost !== 8'd0) begin failures++; $display("FAIL nom_max0 got=%0d exp=0", max_cost); end
  endtask

  task automatic test_rounding();
    for (int i = 0; i < 7; i++) feed(8'd1);
    feed(8'd4);
    checks++; if (batch_total !== 11'd11) begin failures++; $display("FAIL rnd_total11 got=%0d exp=11", batch_total); end
    checks++; if (avg_cost !== 8'd1) begin failures++; $display("FAIL rnd_avg11 got=%0d exp=1", avg_cost); end
    handshake();
    for (int i = 0; i < 7; i++) feed(8'd1);
    feed(8'd5);
    checks++; if (batch_total !== 11'd12) begin failures++; $display("FAIL rnd_total12 got=%0d exp=12", batch_total); end
    checks++; if (avg_cost !== 8'd2) begin failures++; $display("FAIL rnd_avg12 got=%0d exp=2", avg_cost); end
    handshake();
  endtask

  task automatic test_extreme();
    for (int i = 0; i < 8; i++) feed(8'd255);
    checks++; if (batch_total !== 11'd2040) begin failures++; $display("FAIL ext_total got=%0d exp=2040", batch_total); end
    checks++; if (avg_cost !== 8'd255) begin failures++; $display("FAIL ext_avg got=%0d exp=255", avg_cost); end
    checks++; if (max_cost !== 8'd255) begin failures++; $display("FAIL ext_max got=%0d exp=255", max_cost); end
    handshake();
  endtask

  task automatic test_backpressure();
    for (int i = 0; i < 8; i++) feed(8'(i));
    for (int i = 0; i < 5; i++) begin
      cost_en = (i == 1);
      @(negedge clk);
      checks++; if (avg_valid !== 1'b1 || accept !== 1'b0) begin failures++; $display("FAIL bp_hold%0d got=v%0d/a%0d exp=v1/a0", i, avg_valid, accept); end
      checks++; if (batch_total !== 11'd28 || avg_cost !== 8'd4 || max_cost !== 8'd7) begin failures++; $display("FAIL bp_stable%0d got=%0d/%0d/%0d exp=28/4/7", i, batch_total, avg_cost, max_cost); end
    end
    cost_en = 1'b0;
    checks++; if (drop_err !== 1'b1) begin failures++; $display("FAIL bp_drop got=%0d exp=1", drop_err); end
    checks++; if (sample_count !== 4'd8) begin failures++; $display("FAIL bp_count8 got=%0d exp=8", sample_count); end
    handshake();
    checks++; if (accept !== 1'b1 || sample_count !== 4'd0) begin failures++; $display("FAIL bp_idle got=a%0d/c%0d exp=a1/c0", accept, sample_count); end
    checks++; if (drop_err !== 1'b1) begin failures++; $display("FAIL bp_drop_sticky got=%0d exp=1", drop_err); end
    clear = 1'b1; @(negedge clk); clear = 1'b0;
    checks++; if (drop_err !== 1'b0) begin failures++; $display("FAIL bp_drop_clear got=%0d exp=0", drop_err); end
  endtask

  task automatic test_stale_flag();
    cost_en = 1'b1; calculation_complete = 1'b1; cost_in = 8'd99;
    @(negedge clk);
    cost_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++; if (busy !== 1'b1 || sample_count !== 4'd0) begin failures++; $display("FAIL stale_wait%0d got=b%0d/c%0d exp=b1/c0", i, busy, sample_count); end
    end
    calculation_complete = 1'b0; cost_in = 8'd77;
    @(negedge clk);
    calculation_complete = 1'b1; cost_in = 8'd42;
    @(negedge clk);
    cost_in = 8'd13;
    @(negedge clk);
    checks++; if (sample_count !== 4'd1) begin failures++; $display("FAIL stale_count got=%0d exp=1", sample_count); end
    checks++; if (batch_total !== 11'd42) begin failures++; $display("FAIL stale_capture got=%0d exp=42", batch_total); end
    clear = 1'b1; @(negedge clk); clear = 1'b0;
  endtask

  task automatic test_clear_report();
    for (int i = 0; i < 8; i++) feed(8'd2);
    clear = 1'b1; avg_ready = 1'b1;
    @(negedge clk);
    clear = 1'b0; avg_ready = 1'b0;
    checks++; if (avg_valid !== 1'b0 || sample_count !== 4'd0 || batch_total !== 11'd0) begin failures++; $display("FAIL clr_report got=v%0d/c%0d/t%0d exp=0/0/0", avg_valid, sample_count, batch_total); end
  endtask

  task automatic test_abort();
    feed(8'd5); feed(8'd6); feed(8'd7);
    checks++; if (sample_count !== 4'd3 || batch_total !== 11'd18) begin failures++; $display("FAIL abort_pre got=c%0d/t%0d exp=3/18", sample_count, batch_total); end
    clear = 1'b1; @(negedge clk); clear = 1'b0;
    checks++; if (sample_count !== 4'd0 || batch_total !== 11'd0 || max_cost !== 8'd0) begin failures++; $display("FAIL abort_clear got=c%0d/t%0d/m%0d exp=0/0/0", sample_count, batch_total, max_cost); end
    feed(8'd9);
    cost_en = 1'b1; calculation_complete = 1'b1;
    @(negedge clk);
    cost_en = 1'b0; calculation_complete = 1'b0;
    @(negedge clk);
    cost_en = 1'b1;
    @(negedge clk);
    cost_en = 1'b0;
    checks++; if (drop_err !== 1'b1 || busy !== 1'b1) begin failures++; $display("FAIL abort_waitdone got=d%0d/b%0d exp=1/1", drop_err, busy); end
    #2 n_rst = 1'b0;
    #1;
    checks++; if (busy !== 1'b0 || accept !== 1'b1 || avg_valid !== 1'b0) begin failures++; $display("FAIL async_rst_ctl got=b%0d/a%0d/v%0d exp=0/1/0", busy, accept, avg_valid); end
    checks++; if (sample_count !== 4'd0 || batch_total !== 11'd0 || max_cost !== 8'd0 || drop_err !== 1'b0) begin failures++; $display("FAIL async_rst_data got=c%0d/t%0d/m%0d/d%0d exp=0/0/0/0", sample_count, batch_total, max_cost, drop_err); end
    @(negedge clk);
    n_rst = 1'b1; calculation_complete = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_rounding();
    test_extreme();
    test_backpressure();
    test_stale_flag();
    test_clear_report();
    test_abort();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/batch_cost_accumulator.md
Name: batch_cost_accumulator

Overview:
- Downstream of the per-sample cost calculator.
- Watches each cost calculation run and captures the finished 8-bit squared-error cost.
- Accumulates costs over a batch of 2^BATCH_LOG2 samples, then presents a rounded batch average, the batch total and the maximum cost to the training controller over a valid/ready handshake.

Parameters:
- BATCH_LOG2, 3, log2 of samples per batch (batch = 8 by default); legal range 1..6.
- COST_W, 8, width of the per-sample cost input and the average/max outputs.

Ports:
- clk  input  1  system clock, rising edge.
- n_rst  input  1  asynchronous, active-low reset.
- clear  input  1  synchronous batch abort/clear, active high.
- cost_en  input  1  same strobe that starts the cost calculator; marks the start of one sample.
- calculation_complete  input  1  calculator idle flag; high whenever the calculator is idle.
- cost_in  input  COST_W  calculator cost output; valid while calculation_complete is high after a run.
- accept  output  1  high when a new cost_en is allowed (IDLE only).
- busy  output  1  high in any state other than IDLE.
- sample_count  output  BATCH_LOG2+1  samples accumulated in the current batch, 0..2^BATCH_LOG2.
- avg_valid  output  1  batch result valid.
- avg_ready  input  1  consumer accepts the batch result.
- avg_cost  output  COST_W  rounded average cost.
- batch_total  output  COST_W+BATCH_LOG2  sum of batch costs.
- max_cost  output  COST_W  largest single cost in the batch.
- drop_err  output  1  sticky: a cost_en arrived while accept was low.

Behaviour:
- Reset (n_rst low, asynchronous):
  - state IDLE.
  - accumulator, sample_count, max_cost, sample register and drop_err cleared to 0.
  - avg_valid = 0, busy = 0, accept = 1.
- FSM states: IDLE, WAIT_START, WAIT_DONE, ACCUM, REPORT.
  - IDLE: accept = 1. cost_en = 1 goes to WAIT_START.
  - WAIT_START: wait for calculation_complete = 0 (the calculator has left idle), then go to WAIT_DONE. This rejects the stale high level of calculation_complete.
  - WAIT_DONE: when calculation_complete = 1, latch cost_in into the sample register and go to ACCUM.
  - ACCUM (one cycle):
    - accumulator += sample, with no overflow possible at the parameter widths.
    - max_cost = max(max_cost, sample).
    - sample_count += 1.
    - If the incremented count equals 2^BATCH_LOG2, go to REPORT; otherwise go to IDLE.
  - REPORT:
    - avg_valid = 1; avg_cost, batch_total and max_cost are held stable.
    - avg_ready = 1 completes the handshake in that cycle. Next cycle: IDLE with accumulator, sample_count and max_cost cleared.
    - avg_ready may be high before avg_valid; only the overlap counts.
- Average: avg_cost = (batch_total + 2^(BATCH_LOG2-1)) >> BATCH_LOG2, round half up. It always fits COST_W; 8 x 255 gives 255.
- batch_total and max_cost are visible at all times as running values; they are only meaningful as a batch result while avg_valid = 1.
- Latency: cycle N is the first cycle with calculation_complete = 1 in WAIT_DONE. sample_count and batch_total update at the end of N+1. For the last sample, avg_valid rises in cycle N+2.
- accept is low outside IDLE.
  - cost_en while accept = 0 sets drop_err.
  - The sample is not counted and the state is unchanged.
  - drop_err is cleared only by reset or clear.
- clear = 1 in any state, including REPORT:
  - Next state IDLE; accumulator, sample_count, max_cost and drop_err are zeroed; avg_valid drops the next cycle.
  - clear has priority over cost_en and avg_ready in the same cycle.
- Zero cost samples are counted normally.
- Reset asserted mid-batch discards the partial batch; no output is produced for it.

Optional Feature:
- Macro: BATCH_COST_MIN_TRACK_EN.
- Defined:
  - Adds output port min_cost (COST_W).
  - min_cost resets to all-ones and is reset to all-ones on clear and after each REPORT handshake.
  - In ACCUM: min_cost = min(min_cost, sample).
  - Held stable in REPORT alongside max_cost.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- Nominal batch (default params): costs 10,20,30,40,50,60,70,80 with avg_ready = 1 -> avg_valid pulses 1 cycle; batch_total = 360, avg_cost = 45, max_cost = 80; sample_count returns to 0 afterwards.
- Rounding: seven costs of 1 plus one of 4 (total 11) -> avg_cost = 1; seven 1s plus one 5 (total 12) -> avg_cost = 2 (half rounds up).
- Saturation-free extreme: eight costs of 255 -> batch_total = 2040, avg_cost = 255, max_cost = 255.
- Backpressure: avg_ready = 0 for 5 cycles in REPORT -> outputs are stable and accept = 0; cost_en pulsed during this window -> drop_err = 1 and sample_count stays at 8; then avg_ready = 1 -> IDLE, count 0, drop_err still 1.
- Stale-flag rejection: cost_en with calculation_complete held high for 3 cycles before dropping -> no capture until a fresh low-to-high transition; the captured value equals cost_in at that rising cycle.
- Abort: clear after 3 samples -> sample_count = 0 and batch_total = 0; n_rst asserted asynchronously mid-WAIT_DONE -> all outputs at reset values within the same cycle.
